// File: rtl/sfifo_pkg.sv
// Shared helpers for the sfifo_flex family: address-width derivation and
// parameter legality checks used at elaboration.
package sfifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit params_ok(input int depth, input int af_level,
                                   input int ae_level, input int fwft);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port RAM, one clock, registered read port with reset on the
// output register so the read data has a defined value after reset.
module sfifo_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

  // storage array, written on accepted writes
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // registered read port, holds when not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= {WIDTH{1'b0}};
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end else begin
      o_rdata <= o_rdata;
    end
  end

endmodule

// File: rtl/sfifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// error flags and an optional first-word-fall-through read port.
module sfifo_flex
  import sfifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   winc,
  input  logic                   rinc,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   clr_err,
  output logic                   wfull,
  output logic                   rempty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  output logic [WIDTH-1:0]       rdata
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam bit IS_FWFT = (FWFT != 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $error("sfifo_flex: illegal DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
  end

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_wfull;
  logic          r_rempty;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic          r_udf;
  logic          r_ov;

  logic          w_wen;
  logic          w_ren;
  logic          w_ram_has_data;
  logic          w_ram_ren;
  logic          w_ov_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_rempty_nxt;
  logic          w_ovf_nxt;
  logic          w_udf_nxt;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_wen          = winc & ~r_wfull;
  assign w_ren          = rinc & ~r_rempty;
  assign w_ram_has_data = (r_wptr != r_rptr);

  // RAM read enable and head-register valid; in FWFT mode the RAM read
  // register doubles as the head register and is refilled whenever free
  always_comb begin
    w_ram_ren = w_ren;
    w_ov_nxt  = 1'b0;
    if (IS_FWFT) begin
      w_ram_ren = w_ram_has_data & (~r_ov | w_ren);
      if (w_ram_ren) begin
        w_ov_nxt = 1'b1;
      end else if (w_ren) begin
        w_ov_nxt = 1'b0;
      end else begin
        w_ov_nxt = r_ov;
      end
    end else begin
      w_ram_ren = w_ren;
      w_ov_nxt  = 1'b0;
    end
  end

  // next count, empty and sticky error values
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wen, w_ren})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (IS_FWFT) begin
      w_rempty_nxt = ~w_ov_nxt;
    end else begin
      w_rempty_nxt = (w_count_nxt == CW'(0));
    end
    w_ovf_nxt = (winc & r_wfull) | (r_ovf & ~clr_err);
    w_udf_nxt = (rinc & r_rempty) | (r_udf & ~clr_err);
  end

  // pointers, count and all flags, registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= PW'(0);
      r_rptr   <= PW'(0);
      r_count  <= CW'(0);
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_wptr   <= w_wen ? r_wptr + PW'(1) : r_wptr;
      r_rptr   <= w_ram_ren ? r_rptr + PW'(1) : r_rptr;
      r_count  <= w_count_nxt;
      r_wfull  <= (w_count_nxt == DEPTH_C);
      r_rempty <= w_rempty_nxt;
      r_af     <= (w_count_nxt >= AF_C);
      r_ae     <= (w_count_nxt <= AE_C);
      r_ovf    <= w_ovf_nxt;
      r_udf    <= w_udf_nxt;
      r_ov     <= w_ov_nxt;
    end
  end

  sfifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wen),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (wdata),
    .i_re    (w_ram_ren),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign wfull        = r_wfull;
  assign rempty       = r_rempty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign rdata        = w_ram_rdata;

endmodule

// File: tb/tb_sfifo_flex.sv
// Directed bench: a standard-mode and an FWFT-mode instance driven side by
// side, with hand-derived expectations checked by immediate assertions.
module tb_sfifo_flex;

  logic       clk;
  logic       rst_n;
  logic       winc0, rinc0, clr0;
  logic [7:0] wdata0;
  logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic [4:0] count0;
  logic [7:0] rdata0;
  logic       winc1, rinc1, clr1;
  logic [7:0] wdata1;
  logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [4:0] count1;
  logic [7:0] rdata1;

  int checks = 0;
  int errors = 0;

  sfifo_flex #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc0), .rinc(rinc0), .wdata(wdata0),
    .clr_err(clr0), .wfull(wfull0), .rempty(rempty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0),
    .rdata(rdata0)
  );

  sfifo_flex #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc1), .rinc(rinc1), .wdata(wdata1),
    .clr_err(clr1), .wfull(wfull1), .rempty(rempty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1),
    .rdata(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    winc0 = 1'b0; rinc0 = 1'b0; clr0 = 1'b0; wdata0 = 8'h00;
    winc1 = 1'b0; rinc1 = 1'b0; clr1 = 1'b0; wdata1 = 8'h00;
    #12;
    chk("rst_wfull",  32'(wfull0),  32'd0);
    chk("rst_rempty", 32'(rempty0), 32'd1);
    chk("rst_af",     32'(af0),     32'd0);
    chk("rst_ae",     32'(ae0),     32'd1);
    chk("rst_count",  32'(count0),  32'd0);
    chk("rst_ovf",    32'(ovf0),    32'd0);
    chk("rst_udf",    32'(udf0),    32'd0);
    chk("rst_rdata",  32'(rdata0),  32'd0);
    chk("rst_rempty1", 32'(rempty1), 32'd1);
    rst_n = 1'b1;

    // 1: fill standard FIFO, then overflow
    for (int i = 1; i <= 16; i++) begin
      winc0 = 1'b1; wdata0 = 8'(i);
      tick();
      chk("fill_count", 32'(count0), 32'(i));
      chk("fill_af",    32'(af0),    32'(i >= 12));
      chk("fill_ae",    32'(ae0),    32'(i <= 4));
      chk("fill_wfull", 32'(wfull0), 32'(i == 16));
    end
    wdata0 = 8'h11;
    tick();
    winc0 = 1'b0;
    chk("ovf_set",   32'(ovf0),   32'd1);
    chk("ovf_count", 32'(count0), 32'd16);
    chk("ovf_wfull", 32'(wfull0), 32'd1);

    // 2: drain in order, then underflow and clear
    for (int i = 1; i <= 16; i++) begin
      rinc0 = 1'b1;
      tick();
      chk("drain_rdata",  32'(rdata0),  32'(i));
      chk("drain_rempty", 32'(rempty0), 32'(i == 16));
      chk("drain_count",  32'(count0),  32'(16 - i));
    end
    tick();
    rinc0 = 1'b0;
    chk("udf_set",   32'(udf0),   32'd1);
    chk("udf_rdata", 32'(rdata0), 32'h10);
    chk("udf_count", 32'(count0), 32'd0);
    rinc0 = 1'b1; clr0 = 1'b1;
    tick();
    rinc0 = 1'b0;
    chk("set_wins_udf", 32'(udf0), 32'd1);
    chk("clr_ovf",      32'(ovf0), 32'd0);
    tick();
    clr0 = 1'b0;
    chk("clr_udf", 32'(udf0), 32'd0);
    chk("clr_ovf2", 32'(ovf0), 32'd0);

    // 3: steady simultaneous read/write at count 8 across the wrap
    for (int i = 0; i < 8; i++) begin
      winc0 = 1'b1; wdata0 = 8'(8'h20 + i);
      tick();
    end
    chk("pre_stream_count", 32'(count0), 32'd8);
    for (int k = 0; k < 40; k++) begin
      winc0 = 1'b1; rinc0 = 1'b1; wdata0 = 8'(8'h28 + k);
      tick();
      chk("stream_count", 32'(count0), 32'd8);
      chk("stream_rdata", 32'(rdata0), 32'(8'h20 + k));
    end
    winc0 = 1'b0; rinc0 = 1'b0;
    chk("stream_ovf", 32'(ovf0), 32'd0);
    chk("stream_udf", 32'(udf0), 32'd0);

    // 4: FWFT single word latency and pop
    winc1 = 1'b1; wdata1 = 8'hA5;
    tick();
    winc1 = 1'b0;
    chk("fwft_n_rempty", 32'(rempty1), 32'd1);
    chk("fwft_n_count",  32'(count1),  32'd1);
    tick();
    chk("fwft_n1_rempty", 32'(rempty1), 32'd0);
    chk("fwft_n1_rdata",  32'(rdata1),  32'hA5);
    rinc1 = 1'b1;
    tick();
    rinc1 = 1'b0;
    chk("fwft_pop_rempty", 32'(rempty1), 32'd1);
    chk("fwft_pop_count",  32'(count1),  32'd0);
    chk("fwft_pop_stale",  32'(rdata1),  32'hA5);

    // 5: FWFT fill then continuous pop
    for (int i = 0; i < 16; i++) begin
      winc1 = 1'b1; wdata1 = 8'(8'h31 + i);
      tick();
    end
    winc1 = 1'b0;
    chk("fwft_full_count", 32'(count1), 32'd16);
    chk("fwft_full_wfull", 32'(wfull1), 32'd1);
    chk("fwft_full_af",    32'(af1),    32'd1);
    chk("fwft_head",       32'(rdata1), 32'h31);
    chk("fwft_head_valid", 32'(rempty1), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      rinc1 = 1'b1;
      tick();
      chk("fwft_drain_count",  32'(count1),  32'(16 - k));
      chk("fwft_drain_ae",     32'(ae1),     32'((16 - k) <= 4));
      chk("fwft_drain_rempty", 32'(rempty1), 32'(k == 16));
      if (k < 16) begin
        chk("fwft_drain_rdata", 32'(rdata1), 32'(8'h31 + k));
      end else begin
        chk("fwft_drain_stale", 32'(rdata1), 32'h40);
      end
    end
    tick();
    rinc1 = 1'b0;
    chk("fwft_udf", 32'(udf1), 32'd1);

    // 6: asynchronous reset mid-burst at count 9
    winc0 = 1'b1; wdata0 = 8'h77;
    tick();
    chk("pre_rst_count", 32'(count0), 32'd9);
    wdata0 = 8'h78;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(count0),  32'd0);
    chk("arst_rempty", 32'(rempty0), 32'd1);
    chk("arst_wfull",  32'(wfull0),  32'd0);
    chk("arst_af",     32'(af0),     32'd0);
    chk("arst_ae",     32'(ae0),     32'd1);
    chk("arst_rdata",  32'(rdata0),  32'd0);
    chk("arst_udf1",   32'(udf1),    32'd0);
    chk("arst_rdata1", 32'(rdata1),  32'd0);
    winc0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    winc0 = 1'b1; wdata0 = 8'hC3;
    tick();
    winc0 = 1'b0; rinc0 = 1'b1;
    chk("post_rst_count", 32'(count0), 32'd1);
    tick();
    rinc0 = 1'b0;
    chk("post_rst_rdata",  32'(rdata0),  32'hC3);
    chk("post_rst_rempty", 32'(rempty0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfifo_flex.md
Name: sfifo_flex

Overview:
- Parametrised successor to the basic synchronous FIFO, with a single clock domain.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Offers a compile-time choice between a standard read mode and a first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths that need early back-pressure and error visibility.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: capacity in words; must be a power of two, at least 4.
- AF_LEVEL, 12: almost_full asserts when count >= AF_LEVEL; valid range is 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL; valid range is 0..DEPTH-1.
- FWFT, 0: 0 selects standard read mode; 1 selects first-word-fall-through.

Ports:
- clk, input, 1: the single clock; all logic samples on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- winc, input, 1: write request.
- rinc, input, 1: read request (standard mode) or pop request (FWFT mode).
- wdata, input, WIDTH: write data.
- clr_err, input, 1: synchronous clear of the sticky error flags.
- wfull, output, 1: FIFO full.
- rempty, output, 1: no readable word.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, $clog2(DEPTH)+1: words currently held.
- overflow, output, 1: sticky; a write was attempted while full.
- underflow, output, 1: sticky; a read was attempted while empty.
- rdata, output, WIDTH: read data.

Behaviour:
- Reset: an asynchronous assert of rst_n clears all state at once, including mid-operation. After reset:
  - pointers, count and rdata are 0;
  - wfull=0, rempty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Full means the addresses are equal and the wrap bits differ.
  - Empty means the pointers are equal.
- Write acceptance: wen = winc & !wfull.
  - A write while full is dropped, even if a read happens in the same cycle.
  - The data is stored in the RAM at the write pointer on that edge.
- Read acceptance: ren = rinc & !rempty.
  - A read while empty is ignored, even if a write happens in the same cycle.
- All flags and count are registered and exact: each is computed from the next-state values, so it reflects FIFO state after the current edge, with no one-cycle lag.
- count update:
  - +1 on wen only;
  - -1 on ren only;
  - unchanged when both or neither occur.
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous wen and ren with 0 < count < DEPTH: both execute and count is held.
- overflow is set on the edge where winc=1 and wfull=1.
- underflow is set on the edge where rinc=1 and rempty=1.
- Both error flags are cleared by clr_err=1. If set and clear occur in the same cycle, set wins.
- Standard mode (FWFT=0):
  - rdata is registered and updates on the edge of an accepted read, so it is valid the cycle after ren.
  - rdata holds its value otherwise.
  - rempty = (count == 0).
- FWFT mode (FWFT=1):
  - An output register holds the head word. rempty=0 means rdata is valid now.
  - rinc pops the head word; the next word is preloaded from the RAM so that back-to-back pops sustain one word per cycle.
  - count includes the word in the output register. Total capacity remains DEPTH.
  - Latency into an empty FIFO: a word written on edge N appears on rdata, with rempty=0, after edge N+1.
  - A pop of the last word on edge N gives rempty=1 after edge N; rdata then holds its stale value.
- Wrap-around: the address wraps DEPTH-1 -> 0 and the wrap bit toggles. No behaviour changes at the wrap.

Decomposition:
- Shared package sfifo_pkg holds the ADDR_W = $clog2(DEPTH) helper function and the parameter range checks. The range checks run as elaboration-time assertions.
- One sub-module: sfifo_ram, a simple dual-port RAM with a registered read, the same clock on both ports and write/read enables.
- Pointer, count and flag logic plus the FWFT prefetch stage live in sfifo_flex itself.

Test Plan:
1. Reset, FWFT=0, DEPTH=16: write 16 words 0x01..0x10 -> wfull=1 after the 16th edge, almost_full from count 12, count=16. Then a 17th write -> overflow=1, count stays 16.
2. Read all 16 words -> rdata sequence 0x01..0x10, each valid the cycle after rinc. rempty=1 after the 16th read. A 17th rinc -> underflow=1. clr_err pulse -> both error flags 0.
3. At count=8: hold winc=1 and rinc=1 for 40 cycles -> count stays 8, data stays in order across the pointer wrap, no error flags.
4. FWFT=1: single write 0xA5 on edge N -> rempty=0 and rdata=0xA5 after N+1. rinc pops it -> rempty=1 after the next edge.
5. FWFT=1: fill to 16, then pop continuously -> one word per cycle, ordered, no bubbles. almost_empty asserts at count 4.
6. Assert rst_n low mid-burst at count=9 -> outputs immediately take their reset values, and the next write/read restarts from address 0.
